// File: rtl/astar_pkg.sv
// Shared types and constants for the A* open-set blocks.
package astar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        CLEAR,
        DONE
    } popmin_state_t;

    // All-ones cost of the given width marks an empty queue slot.
    function automatic logic [63:0] empty_cost(input int unsigned width);
        return {64{1'b1}} >> (64 - width);
    endfunction

endpackage

// File: rtl/min_tracker.sv
// Running minimum of sampled costs; strict-less-than update keeps the lowest index on ties.
module min_tracker
    import astar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [ADDR_WIDTH-1:0] sample_addr,
    output logic [DATA_WIDTH-1:0] min_data,
    output logic [ADDR_WIDTH-1:0] min_addr
);

    localparam logic [DATA_WIDTH-1:0] EMPTY_COST = DATA_WIDTH'(empty_cost(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] r_min_data;
    logic [ADDR_WIDTH-1:0] r_min_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_data <= EMPTY_COST;
            r_min_addr <= '0;
        end else if (clear) begin
            r_min_data <= EMPTY_COST;
            r_min_addr <= '0;
        end else if (sample_en && (sample_data < r_min_data)) begin
            r_min_data <= sample_data;
            r_min_addr <= sample_addr;
        end
    end

    assign min_data = r_min_data;
    assign min_addr = r_min_addr;

endmodule

// File: rtl/open_set_pop_min.sv
// Pop-min scanner over the A* cost queue. Define CLEAR_ON_POP_EN to invalidate the popped entry.
module open_set_pop_min
    import astar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_empty,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [DATA_WIDTH-1:0] EMPTY_COST = DATA_WIDTH'(empty_cost(DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    popmin_state_t         r_state;
    popmin_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_cmp_valid;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic                  r_resp_valid;
    logic [ADDR_WIDTH-1:0] r_resp_addr;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_empty;
    logic [DATA_WIDTH-1:0] w_min_data;
    logic [ADDR_WIDTH-1:0] w_min_addr;
    logic                  w_accept;
    logic                  w_last;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_rd_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (req_valid) w_next_state = SCAN;
            SCAN:  if (w_last) w_next_state = DRAIN;
`ifdef CLEAR_ON_POP_EN
            DRAIN: w_next_state = CLEAR;
            CLEAR: w_next_state = DONE;
`else
            DRAIN: w_next_state = DONE;
`endif
            DONE:  if (r_resp_valid && resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read data for address k arrives one cycle after issue, so the compare stage
    // carries a delayed copy of rd_en/rd_addr alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
        end else begin
            if (w_accept)
                r_rd_addr <= '0;
            else if ((r_state == SCAN) && !w_last)
                r_rd_addr <= r_rd_addr + 1'b1;
            r_cmp_valid <= (r_state == SCAN);
            r_cmp_addr  <= r_rd_addr;
        end
    end

    min_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_min_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_accept),
        .sample_en   (r_cmp_valid),
        .sample_data (rd_data),
        .sample_addr (r_cmp_addr),
        .min_data    (w_min_data),
        .min_addr    (w_min_addr)
    );

    // The tracker settles on entry to DONE; the response is captured one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_data  <= '0;
            r_resp_empty <= 1'b0;
        end else if ((r_state == DONE) && !r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_addr  <= w_min_addr;
            r_resp_data  <= w_min_data;
            r_resp_empty <= (w_min_data == EMPTY_COST);
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

`ifdef CLEAR_ON_POP_EN
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  w_do_clear;

    assign w_do_clear = (r_state == CLEAR) && (w_min_data != EMPTY_COST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_do_clear;
            r_wr_data <= w_do_clear ? EMPTY_COST : '0;
            if (w_do_clear) r_wr_addr <= w_min_addr;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
`else
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

    assign req_ready  = (r_state == IDLE);
    assign rd_en      = (r_state == SCAN);
    assign rd_addr    = r_rd_addr;
    assign resp_valid = r_resp_valid;
    assign resp_addr  = r_resp_addr;
    assign resp_data  = r_resp_data;
    assign resp_empty = r_resp_empty;

endmodule
